router_local_ni: RTL
====================

Name: router_local_ni

Overview:
- Router local-port network interface: the RTL endpoint on the opposite side of the testbench's local-port driver/monitor.
- Accepts flits from the testbench-side sender over a valid/ready channel and checks packet framing with a small FSM.
- Buffers accepted flits in a FIFO and returns them (loopback, header fields swapped) over a second valid/ready channel to the testbench-side receiver.
- Used as the reference responder for router local-port bring-up and as the flit-framing checker.

Parameters:
- TYPE_WIDTH, 2, flit type field width; only 2 supported.
- DATA_WIDTH, 32, flit payload width; even, ≥8.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- SWAP_HDR, 1, 1 = swap dst/src halves of head payload on output; 0 = pass unchanged.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_flit  in  TYPE_WIDTH+DATA_WIDTH  {type, payload}, type in MSBs.
- in_valid  in  1  in_flit valid.
- in_ready  out  1  block can accept.
- out_flit  out  TYPE_WIDTH+DATA_WIDTH  {type, payload}.
- out_valid  out  1  out_flit valid.
- out_ready  in  1  downstream accepts.
- pkt_count  out  16  packets fully accepted (TAIL or SINGLE), wraps.
- err_count  out  8  framing errors, saturates at 255.
- busy  out  1  framing FSM in IN_PKT.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Flit types: 2'b00 SINGLE (head+tail), 2'b01 HEAD, 2'b10 BODY, 2'b11 TAIL.
- Transfer occurs on a posedge where valid && ready on the respective channel. Valid must stay high with a stable flit until accepted. Ready may toggle freely.
- Reset (any cycle, including mid-packet):
  - Outputs: in_ready=0 and out_valid=0 while reset is high; out_flit=0, pkt_count=0, err_count=0, busy=0.
  - FIFO is emptied and the FSM goes to IDLE; partial packets are discarded.
  - in_ready=1 in the first cycle after reset deasserts.
- in_ready = !fifo_full && !reset. Registered full flag; no combinational path from out_ready.
- Full FIFO with a simultaneous pop: push is still refused that cycle. in_ready rises the cycle after the pop.
- Framing FSM, evaluated only on an accepted input flit:
  - IDLE + SINGLE: write, pkt_count++, stay IDLE.
  - IDLE + HEAD: write, go to IN_PKT.
  - IDLE + BODY/TAIL: drop (accepted, not written), err_count++, stay IDLE.
  - IN_PKT + BODY: write, stay.
  - IN_PKT + TAIL: write, pkt_count++, go to IDLE.
  - IN_PKT + HEAD/SINGLE: drop, err_count++, stay IN_PKT.
- Dropped flits still complete the handshake (in_ready unaffected), so the sender never stalls on an error.
- Output side:
  - FIFO is first-word-fall-through with a registered output stage.
  - A flit written at edge N drives out_valid=1 after edge N+1 (one cycle of latency) if the output stage is empty or popped at N+1.
  - out_flit holds while out_valid && !out_ready.
  - Full throughput: one flit per cycle sustained when in_valid and out_ready are held high.
- Header transform (SWAP_HDR=1, type HEAD or SINGLE):
  - out payload[DW-1:DW/2] = in payload[DW/2-1:0].
  - out payload[DW/2-1:0] = in payload[DW-1:DW/2].
  - BODY/TAIL payloads and all type fields pass unchanged.
- Counters: pkt_count wraps 16'hFFFF→0. err_count holds at 8'hFF.
- Ordering is strictly FIFO; no flit is reordered or duplicated.

Test Plan:
- Reset then SINGLE 0_1234ABCD, out_ready=1 → out_flit 0_ABCD1234 appears 2 edges after acceptance; pkt_count=1, err_count=0.
- HEAD 1_00020001, BODY 2_DEADBEEF, TAIL 3_CAFEF00D back-to-back, out_ready=1 → outputs 1_00010002, 2_DEADBEEF, 3_CAFEF00D on consecutive cycles; busy high between HEAD and TAIL; pkt_count=1.
- out_ready=0, stream 6 BODY-framed flits (HEAD+4 BODY+TAIL) with DEPTH=4 → in_ready drops after the FIFO and output stage are full. Raise out_ready: all 6 flits emerge in order with no loss, and in_ready returns the cycle after the first pop.
- In IDLE send BODY 2_11111111, then HEAD, HEAD, TAIL → first BODY and second HEAD dropped; err_count=2; output carries HEAD(swapped), TAIL only; pkt_count=1.
- Send HEAD + 2 BODY, assert reset for 1 cycle mid-packet, then SINGLE 0_00050006 → nothing from the old packet emerges; output 0_00060005; busy=0; pkt_count=1.
- 256 consecutive IDLE-state TAIL flits → err_count saturates at 8'hFF; in_ready never deasserts; out_valid stays 0.

Source files
------------

// File: rtl/router_local_ni.sv
// router_local_ni: router local-port network interface.
// This block accepts flits on a valid/ready input channel and checks their packet framing.
// It buffers the legal flits in a FIFO and loops them back on a valid/ready output channel.
// When SWAP_HDR is set, the dst/src halves of HEAD and SINGLE payloads are swapped on the way out.
module router_local_ni #(
   parameter int unsigned TYPE_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter bit          SWAP_HDR   = 1'b1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [TYPE_WIDTH+DATA_WIDTH-1:0] in_flit,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [TYPE_WIDTH+DATA_WIDTH-1:0] out_flit,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [15:0]                      pkt_count,
   output logic [7:0]                       err_count,
   output logic                             busy
);

   localparam int unsigned FW = TYPE_WIDTH + DATA_WIDTH;
   localparam int unsigned HW = DATA_WIDTH / 2;
   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [TYPE_WIDTH-1:0] TySingle = 2'b00;
   localparam logic [TYPE_WIDTH-1:0] TyHead   = 2'b01;
   localparam logic [TYPE_WIDTH-1:0] TyBody   = 2'b10;
   localparam logic [TYPE_WIDTH-1:0] TyTail   = 2'b11;

   typedef enum logic {StIdle, StInPkt} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [TYPE_WIDTH-1:0] w_in_type;
   logic                  w_accept;
   logic                  w_write;
   logic                  w_pkt_inc;
   logic                  w_err_inc;

   logic [FW-1:0]         r_mem [DEPTH];
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [AW:0]           r_count;
   logic [AW:0]           w_count_next;
   logic                  r_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;

   logic [FW-1:0]         w_head;
   logic [FW-1:0]         w_head_xf;
   logic [TYPE_WIDTH-1:0] w_head_type;
   logic [FW-1:0]         r_out_flit;
   logic                  r_out_valid;
   logic [15:0]           r_pkt_count;
   logic [7:0]            r_err_count;

   // Ready comes only from the registered full flag, so there is no path from out_ready.
   assign in_ready  = !r_full && !reset;
   assign w_accept  = in_valid && in_ready;
   assign w_in_type = in_flit[FW-1:DATA_WIDTH];
   assign w_push    = w_accept && w_write;
   assign w_empty   = (r_count == '0);
   assign w_pop     = !w_empty && (!r_out_valid || out_ready);

   assign out_flit  = r_out_flit;
   assign out_valid = r_out_valid && !reset;
   assign pkt_count = r_pkt_count;
   assign err_count = r_err_count;
   assign busy      = (r_state == StInPkt);

   // Framing state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Framing decisions. Dropped flits are still accepted but are never written.
   always_comb begin
      w_state_next = r_state;
      w_write      = 1'b0;
      w_pkt_inc    = 1'b0;
      w_err_inc    = 1'b0;
      if (w_accept) begin
         case (r_state)
            StIdle: begin
               if (w_in_type == TySingle) begin
                  w_write   = 1'b1;
                  w_pkt_inc = 1'b1;
               end else if (w_in_type == TyHead) begin
                  w_write      = 1'b1;
                  w_state_next = StInPkt;
               end else begin
                  w_err_inc = 1'b1;
               end
            end
            StInPkt: begin
               if (w_in_type == TyBody) begin
                  w_write = 1'b1;
               end else if (w_in_type == TyTail) begin
                  w_write      = 1'b1;
                  w_pkt_inc    = 1'b1;
                  w_state_next = StIdle;
               end else begin
                  w_err_inc = 1'b1;
               end
            end
            default: w_state_next = StIdle;
         endcase
      end
   end

   // Occupancy after this cycle's push and pop.
   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // FIFO pointers, occupancy, and the registered full flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= w_count_next;
         r_full  <= (w_count_next == (AW + 1)'(DEPTH));
      end
   end

   // FIFO storage. It needs no reset because the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wptr] <= in_flit;
      end
   end

   assign w_head      = r_mem[r_rptr];
   assign w_head_type = w_head[FW-1:DATA_WIDTH];

   // Header halves are swapped as the flit moves into the output stage.
   always_comb begin
      w_head_xf = w_head;
      if (SWAP_HDR && ((w_head_type == TySingle) || (w_head_type == TyHead))) begin
         w_head_xf = {w_head_type, w_head[HW-1:0], w_head[DATA_WIDTH-1:HW]};
      end
   end

   // Registered output stage. It refills in the same cycle it is drained.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_flit  <= '0;
      end else if (w_pop) begin
         r_out_valid <= 1'b1;
         r_out_flit  <= w_head_xf;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Packet counter wraps and error counter saturates.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pkt_count <= '0;
         r_err_count <= '0;
      end else begin
         if (w_pkt_inc) begin
            r_pkt_count <= r_pkt_count + 16'd1;
         end
         if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end

endmodule
